// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path.
//   rx_state_e      : frame sequencer states (IDLE, DATA, PARITY, STOP)
//   PS2_BREAK       : key-release prefix byte (F0)
//   PS2_EXT         : extended-key prefix byte (E0)
//   PS2_FRAME_BITS  : start + 8 data + parity + stop
// -----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

endpackage : ps2_pkg

// File: rtl/ps2_rx_frame.sv
// -----------------------------------------------------------------------------
// ps2_rx_frame
// Bit-level PS/2 frame receiver: detects falling edges of the debounced PS/2
// clock, sequences start/data/parity/stop, checks odd parity and abandons a
// frame whose edges stop arriving.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   ps2_clk_i     : debounced PS/2 clock line
//   ps2_data_i    : debounced PS/2 data line
//   byte_o        : received byte, valid while byte_done_o is high
//   byte_done_o   : one-cycle pulse, a clean frame was received
//   err_o         : one-cycle pulse on any frame error (including timeout)
//   timeout_o     : one-cycle pulse when a frame was abandoned for inactivity
// -----------------------------------------------------------------------------
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_done_o,
  output logic       err_o,
  output logic       timeout_o
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYC);

  rx_state_e        state_q, state_d;
  logic             clk_prev_q;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             par_ok_q, par_ok_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             byte_done_q, byte_done_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;
  logic             fall;
  logic             tmo_hit;

  assign fall    = clk_prev_q & ~ps2_clk_i;
  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TMO_LIM);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    par_ok_d    = par_ok_q;
    byte_done_d = 1'b0;
    err_d       = 1'b0;
    timeout_d   = 1'b0;
    tmo_cnt_d   = (state_q == IDLE || fall) ? '0 : tmo_cnt_q + CNT_W'(1);

    if (tmo_hit) begin
      // Timeout wins over a coincident edge; that edge is dropped.
      state_d   = IDLE;
      err_d     = 1'b1;
      timeout_d = 1'b1;
      tmo_cnt_d = '0;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!ps2_data_i) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;  // a start bit must be 0
          end
        end
        DATA: begin
          shreg_d   = {ps2_data_i, shreg_q[7:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shreg_q, ps2_data_i};  // odd parity over data + parity bit
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (ps2_data_i && par_ok_q) byte_done_d = 1'b1;
          else                        err_d       = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_prev_q  <= 1'b1;  // an idle-high line must not look like a fall out of reset
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      par_ok_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_prev_q  <= ps2_clk_i;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      par_ok_q    <= par_ok_d;
      tmo_cnt_q   <= tmo_cnt_d;
      byte_done_q <= byte_done_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  // The shift register is only touched in DATA, so it is stable during the
  // byte_done pulse that follows the stop edge.
  assign byte_o      = shreg_q;
  assign byte_done_o = byte_done_q;
  assign err_o       = err_q;
  assign timeout_o   = timeout_q;

endmodule : ps2_rx_frame

// File: rtl/ps2_rx_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_rx_ctrl
// PS/2 device-to-host receive controller. Wraps the frame receiver with a
// prefix stage that folds E0/F0 into flags and a one-entry valid/ready slot
// towards the keyboard-decode logic.
// Ports:
//   clk, rst_n               : system clock, asynchronous active-low reset
//   ps2_clk_db, ps2_data_db  : debounced PS/2 clock and data lines
//   code_data                : scan code without prefixes
//   code_ext, code_break     : code was preceded by E0 / F0
//   code_valid, code_ready   : handshake; fields stable while valid is high
//   frame_err                : one-cycle pulse on any frame error
//   overrun                  : one-cycle pulse when a completed code is dropped
// -----------------------------------------------------------------------------
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_db,
  input  logic       ps2_data_db,
  output logic [7:0] code_data,
  output logic       code_ext,
  output logic       code_break,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       frame_err,
  output logic       overrun
);

  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_timeout;

  logic [7:0] code_data_q, code_data_d;
  logic       code_ext_q, code_ext_d;
  logic       code_break_q, code_break_d;
  logic       code_valid_q, code_valid_d;
  logic       overrun_q, overrun_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;
  logic       slot_free;

  ps2_rx_frame #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_i   (ps2_clk_db),
    .ps2_data_i  (ps2_data_db),
    .byte_o      (rx_byte),
    .byte_done_o (rx_done),
    .err_o       (frame_err),
    .timeout_o   (rx_timeout)
  );

  // The slot can take a new code if empty or if it is being drained this cycle.
  assign slot_free = ~code_valid_q | code_ready;

  always_comb begin
    code_data_d  = code_data_q;
    code_ext_d   = code_ext_q;
    code_break_d = code_break_q;
    code_valid_d = code_valid_q;
    overrun_d    = 1'b0;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;

    if (code_valid_q && code_ready) code_valid_d = 1'b0;

    // An abandoned frame may have belonged to a prefixed sequence.
    if (rx_timeout) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end

    if (rx_done) begin
      unique case (rx_byte)
        PS2_BREAK: brk_pend_d = 1'b1;
        PS2_EXT:   ext_pend_d = 1'b1;
        default: begin
          if (slot_free) begin
            code_data_d  = rx_byte;
            code_ext_d   = ext_pend_q;
            code_break_d = brk_pend_q;
            code_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_data_q  <= '0;
      code_ext_q   <= 1'b0;
      code_break_q <= 1'b0;
      code_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
    end else begin
      code_data_q  <= code_data_d;
      code_ext_q   <= code_ext_d;
      code_break_q <= code_break_d;
      code_valid_q <= code_valid_d;
      overrun_q    <= overrun_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
    end
  end

  assign code_data  = code_data_q;
  assign code_ext   = code_ext_q;
  assign code_break = code_break_q;
  assign code_valid = code_valid_q;
  assign overrun    = overrun_q;

endmodule : ps2_rx_ctrl

// File: tb/tb_ps2_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ps2_rx_ctrl
// Directed bench for ps2_rx_ctrl. PS/2 lines are driven just after a system
// clock edge, as a debouncer flop would. A negedge monitor counts error and
// overrun pulse cycles and logs every code handed over (valid & ready).
// Codes are logged as {ext, break, data[7:0]}.
// -----------------------------------------------------------------------------
module tb_ps2_rx_ctrl;
  import ps2_pkg::*;

  localparam int TMO = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk_db = 1'b1;
  logic       ps2_data_db = 1'b1;
  logic       code_ready = 1'b0;
  logic [7:0] code_data;
  logic       code_ext, code_break, code_valid, frame_err, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int ovr_cnt  = 0;
  logic [9:0] codes[$];

  always #5 clk = ~clk;

  ps2_rx_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_db  (ps2_clk_db),
    .ps2_data_db (ps2_data_db),
    .code_data   (code_data),
    .code_ext    (code_ext),
    .code_break  (code_break),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (overrun)   ovr_cnt++;
    if (code_valid && code_ready) codes.push_back({code_ext, code_break, code_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    ps2_data_db = b;
    tick(4);
    ps2_clk_db = 1'b0;
    tick(4);
    ps2_clk_db = 1'b1;
  endtask

  // Sends the first nbits bits of a frame (start, data LSB-first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [PS2_FRAME_BITS-1:0] fr;
    fr = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(fr[i]);
    ps2_data_db = 1'b1;
    tick(4);
  endtask

  task automatic send(input logic [7:0] b, input logic par);
    send_bits(b, par, 1'b1, PS2_FRAME_BITS);
  endtask

  // Checks that exactly one code was logged and that it matches.
  task automatic expect_one(input string tag, input logic [9:0] exp);
    check({tag, "_count"}, codes.size(), 1);
    if (codes.size() > 0) check({tag, "_code"}, codes[0], exp);
    codes.delete();
  endtask

  initial begin
    int e0, o0;

    // Reset state
    tick(3);
    check("reset_outputs", {code_data, code_ext, code_break, code_valid, frame_err, overrun}, 0);
    rst_n = 1'b1;
    tick(3);

    // 1: single 0x1C frame, latency of 2 clocks from the stop edge
    code_ready = 1'b1;
    codes.delete();
    e0 = err_cnt; o0 = ovr_cnt;
    send_bits(8'h1C, 1'b0, 1'b1, 10);
    ps2_data_db = 1'b1;
    tick(4);
    ps2_clk_db = 1'b0;          // stop-bit fall, launched by this clk edge
    @(negedge clk); check("t1_valid_e0", code_valid, 0);
    @(negedge clk); check("t1_valid_e1", code_valid, 0);
    @(negedge clk); check("t1_valid_e2", code_valid, 1);
    check("t1_fields", {code_ext, code_break, code_data}, {2'b00, 8'h1C});
    @(negedge clk); check("t1_valid_drop", code_valid, 0);
    tick(2);
    ps2_clk_db = 1'b1;
    tick(4);
    expect_one("t1", {2'b00, 8'h1C});
    check("t1_no_err", err_cnt - e0, 0);
    check("t1_no_ovr", ovr_cnt - o0, 0);

    // 2: F0 1C -> break; E0 F0 75 -> ext+break; then plain 1C
    e0 = err_cnt;
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b0);
    expect_one("t2_brk", {2'b01, 8'h1C});
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b1);
    send(8'h75, 1'b0);
    expect_one("t2_extbrk", {2'b11, 8'h75});
    send(8'h1C, 1'b0);
    expect_one("t2_cleared", {2'b00, 8'h1C});
    check("t2_no_err", err_cnt - e0, 0);

    // 3: parity error, stop error, stray fall in IDLE; prefix survives errors
    e0 = err_cnt;
    send(8'h1C, 1'b1);
    check("t3_par_err", err_cnt - e0, 1);
    check("t3_par_nocode", codes.size(), 0);
    e0 = err_cnt;
    send_bits(8'h1C, 1'b0, 1'b0, PS2_FRAME_BITS);
    check("t3_stop_err", err_cnt - e0, 1);
    check("t3_stop_nocode", codes.size(), 0);
    e0 = err_cnt;
    drive_bit(1'b1);
    tick(4);
    check("t3_idle_fall_err", err_cnt - e0, 1);
    e0 = err_cnt;
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b0);
    check("t3_prefix_err", err_cnt - e0, 1);
    expect_one("t3_prefix_kept", {2'b01, 8'h1C});

    // 4: timeout after start + 3 data bits clears a pending F0
    send(8'hF0, 1'b1);
    e0 = err_cnt;
    send_bits(8'h1C, 1'b0, 1'b1, 4);
    tick(TMO - 30);
    check("t4_no_early_err", err_cnt - e0, 0);
    tick(60);
    check("t4_timeout_err", err_cnt - e0, 1);
    check("t4_nocode", codes.size(), 0);
    e0 = err_cnt;
    send(8'h1C, 1'b0);
    expect_one("t4_after", {2'b00, 8'h1C});
    check("t4_after_no_err", err_cnt - e0, 0);

    // 5: backpressure and overrun, ready raised as 0x21 loads
    code_ready = 1'b0;
    o0 = ovr_cnt;
    send(8'h1C, 1'b0);
    check("t5_hold_valid", code_valid, 1);
    check("t5_hold_data", code_data, 8'h1C);
    send(8'h32, 1'b0);
    check("t5_overrun", ovr_cnt - o0, 1);
    check("t5_kept_data", {code_valid, code_data}, {1'b1, 8'h1C});
    o0 = ovr_cnt;
    send_bits(8'h21, 1'b1, 1'b1, 10);
    ps2_data_db = 1'b1;
    tick(4);
    ps2_clk_db = 1'b0;
    tick(1);
    code_ready = 1'b1;          // high during the cycle that loads 0x21
    @(negedge clk);
    @(negedge clk);
    check("t5_new_code", {code_valid, code_ext, code_break, code_data}, {3'b100, 8'h21});
    tick(2);
    ps2_clk_db = 1'b1;
    tick(4);
    check("t5_no_ovr", ovr_cnt - o0, 0);
    check("t5_drained", code_valid, 0);
    check("t5_count", codes.size(), 2);
    if (codes.size() == 2) begin
      check("t5_first", codes[0], {2'b00, 8'h1C});
      check("t5_second", codes[1], {2'b00, 8'h21});
    end
    codes.delete();

    // 6: asynchronous reset mid-frame with a code pending
    code_ready = 1'b0;
    send(8'h1C, 1'b0);
    check("t6_pending", code_valid, 1);
    e0 = err_cnt; o0 = ovr_cnt;
    send_bits(8'h75, 1'b0, 1'b1, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", {code_data, code_ext, code_break, code_valid, frame_err, overrun}, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    code_ready = 1'b1;
    send(8'h1C, 1'b0);
    expect_one("t6_after", {2'b00, 8'h1C});
    check("t6_no_err", err_cnt - e0, 0);
    check("t6_no_ovr", ovr_cnt - o0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ps2_rx_ctrl
